axis_bram_reader_m00_axis: RTL and testbench
============================================

Name: axis_bram_reader_m00_axis

Overview:
- AXI-Stream master that streams a contiguous region of a block RAM out on M_AXIS.
- Sits on the transmit side of the BRAM adapter and mirrors the S00 sink, which writes stream data into the buffer.
- A START pulse with BASE_ADDR and LEN launches one packet of LEN beats; TLAST is asserted on the final beat.
- BRAM read latency is hidden by a small prefetch FIFO, so the block sustains 1 beat/cycle under continuous TREADY.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, stream and BRAM data width (multiple of 8).
- C_ADDR_WIDTH, 10, BRAM word-address width.
- C_LEN_WIDTH, 11, packet length field width (maximum LEN = 2^C_LEN_WIDTH-1).

Ports:
- M_AXIS_ACLK  in  1  single clock for all logic.
- M_AXIS_ARESET  in  1  asynchronous, active-high reset.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  beat data.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte qualifier; constant all-ones.
- M_AXIS_TLAST  out  1  final beat of packet.
- M_AXIS_TREADY  in  1  downstream accept.
- START  in  1  one-cycle launch pulse.
- BASE_ADDR  in  C_ADDR_WIDTH  first BRAM word address.
- LEN  in  C_LEN_WIDTH  number of beats in the packet.
- BUSY  out  1  packet in progress.
- DONE  out  1  one-cycle pulse on packet completion.
- BRAM_EN  out  1  BRAM read enable.
- BRAM_ADDR  out  C_ADDR_WIDTH  BRAM read address.
- BRAM_DIN  in  C_M_AXIS_TDATA_WIDTH  BRAM read data, valid L cycles after BRAM_EN (L=1 by default).

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0 during reset (TSTRB is constant all-ones), state=IDLE, FIFO is empty, all counters are 0, and in-flight reads are discarded. Reset asserted mid-packet aborts the packet with no TLAST and no DONE.
- IDLE: BUSY=0. A START pulse latches BASE_ADDR and LEN.
  - LEN=0: go to FINISH (no beats are emitted).
  - LEN>0: go to STREAM.
- START while BUSY=1 is ignored. LEN and BASE_ADDR are sampled only at START.
- STREAM (BUSY=1): issue counter iss, return pipeline valid shifter, output FIFO of depth D=L+1, beat counter beat.
  - Issue rule: BRAM_EN=1 when iss<LEN and (occupancy + inflight − pop_this_cycle) < D.
  - BRAM_ADDR = BASE_ADDR + iss, modulo 2^C_ADDR_WIDTH (wrap-around is legal).
  - Each issue increments iss.
  - Return data is written into the FIFO exactly L cycles after its issue. Data is never dropped; the credit rule guarantees space.
  - TVALID = FIFO not empty; TDATA = FIFO head.
  - While TVALID=1 and TREADY=0, TDATA and TLAST are held stable.
  - Handshake (TVALID&TREADY) pops the head and increments beat.
  - TLAST = TVALID and (beat == LEN−1).
  - The handshake on the TLAST beat transitions to FINISH.
- FINISH: DONE=1 for exactly one cycle, BUSY=0 from the next cycle, return to IDLE. A START on the DONE cycle is ignored; a START the cycle after is accepted.
- Latency (L=1):
  - START high in cycle 0 → BRAM_EN=1, ADDR=BASE in cycle 1 → TVALID=1 in cycle 3.
  - With TREADY held high there are no bubbles after the first beat.
  - A LEN-beat packet completes its last handshake in cycle LEN+2, with DONE in cycle LEN+3.
- TVALID may deassert between beats only if the FIFO runs empty. This happens only through backpressure recovery, never under continuous TREADY.
- LEN = max value: beat and iss counters are C_LEN_WIDTH wide with no overflow.

Optional Feature:
- Macro BRAM_OUTREG_EN.
- Defined: BRAM primitive output register enabled, so L=2 and FIFO depth D=3. First TVALID arrives one cycle later (cycle 4); full throughput is still required.
- Undefined: L=1, D=2, timing as above.

Test Plan:
- BASE=0x010, LEN=4, BRAM[n]=n, TREADY=1 → TDATA 0x10,0x11,0x12,0x13 in cycles 3–6; TLAST only in cycle 6; DONE in cycle 7.
- LEN=8, TREADY toggles 1,0,0,1,… → every beat delivered once, in order; TDATA stable during stalls; BRAM_EN never exceeds credit.
- BASE=0x3FE, LEN=4 → BRAM_ADDR sequence 0x3FE,0x3FF,0x000,0x001; data follows the same order.
- LEN=0 START → no TVALID; DONE pulse in cycle 2; second START during a LEN=16 packet → ignored, exactly 16 beats emitted.
- Assert M_AXIS_ARESET after beat 3 of LEN=10 → TVALID, BUSY, DONE, BRAM_EN all 0 immediately. A new START with LEN=2 after release → exactly 2 beats with correct TLAST.
- BRAM_OUTREG_EN defined, LEN=4, TREADY=1 → first TVALID in cycle 4, four consecutive beats, DONE in cycle 8.

Source files
------------

// File: rtl/axis_bram_reader_m00_axis.sv
// AXI-Stream master that streams BASE_ADDR..BASE_ADDR+LEN-1 of a block RAM with a credit-guarded prefetch FIFO.
// Define BRAM_OUTREG_EN when the BRAM output register is enabled (read latency 2 instead of 1).
module axis_bram_reader_m00_axis #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int C_ADDR_WIDTH         = 10,
   parameter int C_LEN_WIDTH          = 11
) (
   input  logic                                M_AXIS_ACLK,
   input  logic                                M_AXIS_ARESET,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY,
   input  logic                                START,
   input  logic [C_ADDR_WIDTH-1:0]             BASE_ADDR,
   input  logic [C_LEN_WIDTH-1:0]              LEN,
   output logic                                BUSY,
   output logic                                DONE,
   output logic                                BRAM_EN,
   output logic [C_ADDR_WIDTH-1:0]             BRAM_ADDR,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     BRAM_DIN
);

`ifdef BRAM_OUTREG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif
   localparam int D = L + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   logic [1:0]                      state_q, state_d;
   logic [C_ADDR_WIDTH-1:0]         base_q, base_d;
   logic [C_LEN_WIDTH-1:0]          len_q, len_d;
   logic [C_LEN_WIDTH-1:0]          iss_q, iss_d;
   logic [C_LEN_WIDTH-1:0]          beat_q, beat_d;
   logic [L-1:0]                    vld_q, vld_d;
   logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_q [D];
   logic [1:0]                      wr_ptr_q, rd_ptr_q, cnt_q;
   logic [1:0]                      inflight;
   logic [2:0]                      occ_sum;
   logic [C_M_AXIS_TDATA_WIDTH-1:0] head;
   logic                            pop, push, issue, last_beat, fifo_nempty;

   assign fifo_nempty = (cnt_q != 2'd0);
   assign pop         = fifo_nempty && M_AXIS_TREADY;
   assign push        = vld_q[L-1];
   assign last_beat   = fifo_nempty && (beat_q == len_q - C_LEN_WIDTH'(1));

   always_comb begin
      inflight = '0;
      for (int i = 0; i < L; i++) inflight = inflight + 2'(vld_q[i]);
   end

   // Everything already issued but not yet popped must fit in the FIFO.
   assign occ_sum = 3'(cnt_q) + 3'(inflight);
   assign issue   = (state_q == S_STREAM) && (iss_q < len_q) && (occ_sum < 3'(D) + 3'(pop));

   generate
      for (genvar gi = 0; gi < L; gi++) begin : g_vld
         if (gi == 0) begin : g_first
            assign vld_d[gi] = issue;
         end else begin : g_rest
            assign vld_d[gi] = vld_q[gi-1];
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      iss_d   = iss_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               base_d  = BASE_ADDR;
               len_d   = LEN;
               iss_d   = '0;
               beat_d  = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (issue) iss_d = iss_q + C_LEN_WIDTH'(1);
            if (pop)   beat_d = beat_q + C_LEN_WIDTH'(1);
            // An empty packet passes through here for one cycle so DONE lands two cycles after START.
            if ((len_q == '0) || (pop && last_beat)) state_d = S_FINISH;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
      if (M_AXIS_ARESET) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         iss_q    <= '0;
         beat_q   <= '0;
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         iss_q   <= iss_d;
         beat_q  <= beat_d;
         vld_q   <= vld_d;
         if (push) wr_ptr_q <= (wr_ptr_q == 2'(D-1)) ? 2'd0 : wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == 2'(D-1)) ? 2'd0 : rd_ptr_q + 2'd1;
         cnt_q <= cnt_q + 2'(push) - 2'(pop);
      end
   end

   generate
      for (genvar gi = 0; gi < D; gi++) begin : g_fifo
         always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
            if (M_AXIS_ARESET)
               fifo_q[gi] <= '0;
            else if (push && (wr_ptr_q == 2'(gi)))
               fifo_q[gi] <= BRAM_DIN;
         end
      end
   endgenerate

   always_comb begin
      head = '0;
      for (int i = 0; i < D; i++)
         if (rd_ptr_q == 2'(i)) head = fifo_q[i];
   end

   assign M_AXIS_TVALID = fifo_nempty;
   assign M_AXIS_TDATA  = fifo_nempty ? head : '0;
   assign M_AXIS_TSTRB  = '1;
   assign M_AXIS_TLAST  = last_beat;
   assign BUSY          = (state_q != S_IDLE);
   assign DONE          = (state_q == S_FINISH);
   assign BRAM_EN       = issue;
   assign BRAM_ADDR     = base_q + C_ADDR_WIDTH'(iss_q);

endmodule

// File: tb/tb_axis_bram_reader_m00_axis.sv
// Scoreboard bench for axis_bram_reader_m00_axis; follows BRAM_OUTREG_EN to pick the BRAM latency model.
module tb_axis_bram_reader_m00_axis;

`ifdef BRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int DEPTH = LAT + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tready = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base = '0;
   logic [10:0] len = '0;
   logic        tvalid, tlast, busy, done, bram_en;
   logic [31:0] tdata, bram_din, rd1, rd2;
   logic [3:0]  tstrb;
   logic [9:0]  bram_addr;

   axis_bram_reader_m00_axis dut (
      .M_AXIS_ACLK  (clk),
      .M_AXIS_ARESET(rst),
      .M_AXIS_TVALID(tvalid),
      .M_AXIS_TDATA (tdata),
      .M_AXIS_TSTRB (tstrb),
      .M_AXIS_TLAST (tlast),
      .M_AXIS_TREADY(tready),
      .START        (start),
      .BASE_ADDR    (base),
      .LEN          (len),
      .BUSY         (busy),
      .DONE         (done),
      .BRAM_EN      (bram_en),
      .BRAM_ADDR    (bram_addr),
      .BRAM_DIN     (bram_din)
   );

   initial forever #5 clk = ~clk;

   // BRAM model: word n holds value n.
   always @(posedge clk) begin
      if (bram_en) rd1 <= 32'(bram_addr);
      rd2 <= rd1;
   end
   assign bram_din = (LAT == 2) ? rd2 : rd1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   logic [32:0] exp_data [$];
   logic [9:0]  exp_addr [$];
   int start_cyc = 0, mode = 0, cur_len = 0;
   int first_valid_rel = -1, last_rel = -1, done_rel = -1;
   int beats = 0, lasts = 0, dones = 0, bubbles = 0, issued = 0, popped = 0;
   logic        stall_pending = 1'b0;
   logic [33:0] stall_snap = '0;

   // TREADY pattern 1,0,0,1 repeating in mode 1, otherwise held high.
   initial begin
      logic [3:0] pat;
      int ph;
      pat = 4'b1001;
      ph  = 0;
      forever begin
         @(posedge clk);
         #1;
         tready = (mode == 1) ? pat[ph] : 1'b1;
         ph = (ph + 1) % 4;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_pending = 1'b0;
      end else begin
         if (bram_en) begin
            chk("credit", 64'((issued + 1 - popped - int'(tvalid && tready)) <= DEPTH), 64'(1));
            if (exp_addr.size() == 0) chk("addr_extra", 64'(bram_addr), 64'h3ff_ffff);
            else chk("addr", 64'(bram_addr), 64'(exp_addr.pop_front()));
            issued = issued + 1;
         end
         if (stall_pending) chk("stall_hold", 64'({tvalid, tlast, tdata}), 64'(stall_snap));
         stall_pending = tvalid && !tready;
         stall_snap    = {tvalid, tlast, tdata};
         if (tvalid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
         if (!tvalid && mode == 0 && beats > 0 && beats < cur_len) bubbles = bubbles + 1;
         if (tvalid && tready) begin
            if (exp_data.size() == 0) chk("beat_extra", 64'({tlast, tdata}), 64'h1_ffff_ffff_ffff);
            else chk("beat", 64'({tlast, tdata}), 64'(exp_data.pop_front()));
            beats  = beats + 1;
            popped = popped + 1;
            last_rel = cyc - start_cyc;
            if (tlast) lasts = lasts + 1;
         end
         if (done) begin
            done_rel = cyc - start_cyc;
            dones = dones + 1;
         end
      end
   end

   task automatic launch(input logic [9:0] b, input int l, input int m);
      mode = m;
      cur_len = l;
      first_valid_rel = -1; last_rel = -1; done_rel = -1;
      beats = 0; lasts = 0; dones = 0; bubbles = 0;
      for (int i = 0; i < l; i++) begin
         exp_data.push_back({(i == l - 1), 32'(10'(b + 10'(i)))});
         exp_addr.push_back(10'(b + 10'(i)));
      end
      start = 1'b1; base = b; len = 11'(l);
      start_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run(input logic [9:0] b, input int l, input int m, input int ign_at, input bit timing);
      launch(b, l, m);
      for (int k = 0; k < 4 * l + 50 && dones == 0; k++) begin
         start = (k == ign_at);
         base  = 10'h200;
         len   = 11'd5;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      if (dones == 0) chk("done_timeout", 64'(dones), 64'(1));
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      $display("packet base=%0h len=%0d mode=%0d beats=%0d first_valid=%0d done_at=%0d",
               b, l, m, beats, first_valid_rel, done_rel);
      chk("beat_count", 64'(beats), 64'(l));
      chk("tlast_count", 64'(lasts), 64'(l > 0));
      chk("done_count", 64'(dones), 64'(1));
      chk("queues_empty", 64'(exp_data.size() + exp_addr.size()), 64'(0));
      chk("busy_after", 64'(busy), 64'(0));
      if (timing) begin
         if (l == 0) begin
            chk("done_cycle_len0", 64'(done_rel), 64'(2));
            chk("no_valid_len0", 64'(first_valid_rel), 64'(-1));
         end else begin
            chk("first_valid_cycle", 64'(first_valid_rel), 64'(2 + LAT));
            chk("last_beat_cycle", 64'(last_rel), 64'(l + 1 + LAT));
            chk("done_cycle", 64'(done_rel), 64'(l + 2 + LAT));
            chk("bubbles", 64'(bubbles), 64'(0));
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outputs", 64'({tvalid, tlast, busy, done, bram_en, bram_addr, tdata}), 64'(0));
      chk("rst_tstrb", 64'(tstrb), 64'hf);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run(10'h010, 4, 0, -1, 1'b1);
      run(10'h020, 8, 1, -1, 1'b0);
      run(10'h3fe, 4, 0, -1, 1'b1);
      run(10'h000, 0, 0, -1, 1'b1);
      run(10'h100, 16, 0, 5, 1'b1);

      // Abort a LEN=10 packet after its third beat.
      launch(10'h050, 10, 0);
      for (int k = 0; k < 60 && beats < 3; k++) begin
         @(posedge clk);
         #1;
      end
      chk("abort_reached_beat3", 64'(beats), 64'(3));
      rst = 1'b1;
      #1;
      chk("abort_outputs", 64'({tvalid, busy, done, bram_en}), 64'(0));
      chk("abort_no_last_done", 64'({lasts[0], dones[0]}), 64'(0));
      $display("abort after beats=%0d", beats);
      exp_data.delete();
      exp_addr.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      issued = 0;
      popped = 0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run(10'h123, 2, 0, -1, 1'b1);
      run(10'h3f0, 2047, 0, -1, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
